// File: rtl/uart_param_transceiver_if.sv
// Byte-side and serial-side signals of the parametrised UART transceiver.
// master = the client driving TX bytes and the RX line, slave = the transceiver.
interface uart_param_transceiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            i_parity_mode;
    logic                  i_loopback;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic                  o_TX;
    logic                  i_RX;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_rx_parity_error;
    logic                  o_rx_frame_error;

    modport master (
        output i_parity_mode,
        output i_loopback,
        output i_tx_data,
        output i_tx_valid,
        output i_RX,
        input  o_tx_ready,
        input  o_TX,
        input  o_rx_data,
        input  o_rx_valid,
        input  o_rx_parity_error,
        input  o_rx_frame_error
    );

    modport slave (
        input  i_parity_mode,
        input  i_loopback,
        input  i_tx_data,
        input  i_tx_valid,
        input  i_RX,
        output o_tx_ready,
        output o_TX,
        output o_rx_data,
        output o_rx_valid,
        output o_rx_parity_error,
        output o_rx_frame_error
    );
endinterface

// File: rtl/uart_param_transceiver.sv
// Full-duplex UART: independent TX and RX engines with runtime parity,
// 1/2 stop bits, error flags, valid/ready TX handshake and loopback.
module uart_param_transceiver #(
    parameter int DATA_WIDTH          = 8,
    parameter int CLOCKS_PER_BIT      = 434,
    parameter int STOP_BITS           = 1,
    parameter int CLOCK_COUNTER_WIDTH = 10,
    parameter int BIT_COUNTER_WIDTH   = 3
) (
    input  logic i_clock,
    input  logic i_resetL,
    uart_param_transceiver_if.slave bus
);
    localparam int CW = CLOCK_COUNTER_WIDTH;
    localparam int BW = BIT_COUNTER_WIDTH;

    localparam logic [CW-1:0] CPB_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_WAIT   = 3'd5;

    logic [2:0]            tx_state;
    logic [CW-1:0]         tx_cnt;
    logic [BW-1:0]         tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par_en;
    logic                  tx_par_bit;
    logic                  tx_line;
    logic                  tx_cnt_last;

    assign tx_cnt_last = (tx_cnt == CPB_LAST);

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_line    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (bus.i_tx_valid) begin
                        tx_shift   <= bus.i_tx_data;
                        tx_par_en  <= ^bus.i_parity_mode;
                        tx_par_bit <= (^bus.i_tx_data) ^
                                      (bus.i_parity_mode == 2'b10);
                        tx_line    <= 1'b0;
                        tx_cnt     <= '0;
                        tx_bit     <= '0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_last) begin
                        tx_cnt   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_last) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            tx_bit <= '0;
                            if (tx_par_en) begin
                                tx_line  <= tx_par_bit;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt_last) begin
                        tx_cnt   <= '0;
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_last) begin
                        tx_cnt <= '0;
                        if (tx_bit == STOP_LAST) begin
                            tx_bit   <= '0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign bus.o_tx_ready = (tx_state == TX_IDLE);
    assign bus.o_TX       = tx_line | bus.i_loopback;

    logic [2:0]            rx_state;
    logic [CW-1:0]         rx_cnt;
    logic [BW-1:0]         rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    logic                  rx_in;
    logic                  rx_par_en;
    logic                  rx_par_odd;
    logic                  rx_par;
    logic                  rx_cnt_last;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_perr;
    logic                  rx_ferr;

    // Loopback taps the raw TX line, which is already in this clock domain.
    assign rx_in       = bus.i_loopback ? tx_line : rx_sync;
    assign rx_cnt_last = (rx_cnt == CPB_LAST);

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.i_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_in;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_in) begin
                        rx_cnt     <= '0;
                        rx_bit     <= '0;
                        rx_par_en  <= ^bus.i_parity_mode;
                        rx_par_odd <= (bus.i_parity_mode == 2'b10);
                        rx_state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_last) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_in, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_bit == BIT_LAST) begin
                            rx_bit   <= '0;
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_last) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_in;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_last) begin
                        rx_cnt   <= '0;
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        rx_perr  <= rx_par_en &
                                    (rx_par != ((^rx_shift) ^ rx_par_odd));
                        rx_ferr  <= ~rx_in;
                        rx_state <= rx_in ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (rx_in) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.o_rx_data         = rx_data;
    assign bus.o_rx_valid        = rx_valid;
    assign bus.o_rx_parity_error = rx_perr;
    assign bus.o_rx_frame_error  = rx_ferr;
endmodule
